// File: rtl/chip_test_pkg.sv
// Shared types and default sizing for the chip-checker front end and tester mux.
package chip_test_pkg;

    localparam int unsigned CHIP_SEL_W     = 3;
    localparam int unsigned CHIP_NUM_SLOTS = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        SHOW
    } ctrl_state_t;

endpackage

// File: rtl/chip_test_ctrl_if.sv
// Start/select/run/result bundle between the test sequencer and the tester slots.
interface chip_test_ctrl_if
    import chip_test_pkg::*;
#(
    parameter int unsigned NUM_CHIPS = CHIP_NUM_SLOTS,
    parameter int unsigned SEL_W     = CHIP_SEL_W
);

    logic                 Start;
    logic                 Clear;
    logic [SEL_W-1:0]     Sel;
    logic [NUM_CHIPS-1:0] Run;
    logic [NUM_CHIPS-1:0] Done;
    logic [NUM_CHIPS-1:0] RSLT;
    logic                 DISP_RSLT;
    logic                 Busy;
    logic                 Pass;
    logic                 Fail;
    logic                 Timeout;
    logic [SEL_W-1:0]     Slot;

    modport master (
        input  Start, Clear, Sel, Done, RSLT,
        output Run, DISP_RSLT, Busy, Pass, Fail, Timeout, Slot
    );

    modport slave (
        output Start, Clear, Sel, Done, RSLT,
        input  Run, DISP_RSLT, Busy, Pass, Fail, Timeout, Slot
    );

endinterface

// File: rtl/start_debounce.sv
// Start button synchroniser plus stable-level debouncer.
// Only built with CHIP_TEST_CTRL_DEBOUNCE_EN defined.
`ifdef CHIP_TEST_CTRL_DEBOUNCE_EN
module start_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 250_000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic start_raw,
    output logic start_level
);

    localparam int unsigned   CntW    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

    logic [1:0]      sync_q;
    logic            level_q;
    logic [CntW-1:0] cnt_q;

    // Level flips only after DEBOUNCE_CYC consecutive samples of the opposite value.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], start_raw};
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntLast) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign start_level = level_q;

endmodule
`endif

// File: rtl/chip_test_ctrl.sv
// Start-to-result sequencer for the chip-checker tester slots.
// Define CHIP_TEST_CTRL_DEBOUNCE_EN to synchronise and debounce the Start button.
module chip_test_ctrl
    import chip_test_pkg::*;
#(
    parameter int unsigned NUM_CHIPS    = CHIP_NUM_SLOTS,
    parameter int unsigned SEL_W        = CHIP_SEL_W,
    parameter int unsigned TIMEOUT_CYC  = 1_000_000,
    parameter int unsigned DEBOUNCE_CYC = 250_000
) (
    input  logic             Clk,
    input  logic             Reset,
    chip_test_ctrl_if.master bus
);

    localparam int unsigned     CntW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    ctrl_state_t          state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0]     slot_q, slot_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic                 timeout_q, timeout_d;
    logic                 start_q;
    logic                 start_level;
    logic                 start_edge;
    logic                 sel_ok;
    logic [NUM_CHIPS-1:0] run;
    logic                 busy;
    logic                 disp;

`ifdef CHIP_TEST_CTRL_DEBOUNCE_EN
    start_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_start_debounce (
        .Clk         (Clk),
        .Reset       (Reset),
        .start_raw   (bus.Start),
        .start_level (start_level)
    );
`else
    logic unused_debounce_cyc;
    assign unused_debounce_cyc = ^DEBOUNCE_CYC;
    assign start_level         = bus.Start;
`endif

    assign start_edge = start_level & ~start_q;
    assign sel_ok     = 32'(bus.Sel) < NUM_CHIPS;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            slot_q    <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            start_q   <= start_level;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        slot_d    = slot_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        run       = '0;
        busy      = 1'b0;
        disp      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    if (sel_ok) begin
                        state_d = LAUNCH;
                        slot_d  = bus.Sel;
                    end else begin
                        pass_d = 1'b0;
                        fail_d = 1'b1;
                    end
                end else if (bus.Clear) begin
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            LAUNCH: begin
                run[slot_q] = 1'b1;
                busy        = 1'b1;
                pass_d      = 1'b0;
                fail_d      = 1'b0;
                timeout_d   = 1'b0;
                cnt_d       = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                busy  = 1'b1;
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                // Done is checked first so it wins over a coincident terminal count.
                if (bus.Done[slot_q]) begin
                    pass_d  = bus.RSLT[slot_q];
                    fail_d  = ~bus.RSLT[slot_q];
                    state_d = SHOW;
                end else if (cnt_q == CntLast) begin
                    timeout_d = 1'b1;
                    fail_d    = 1'b1;
                    state_d   = SHOW;
                end
            end
            SHOW: begin
                disp = 1'b1;
                if (start_edge) begin
                    if (sel_ok) begin
                        state_d = LAUNCH;
                        slot_d  = bus.Sel;
                    end else begin
                        // Retest on an empty slot: report it like a bad select from IDLE.
                        state_d   = IDLE;
                        pass_d    = 1'b0;
                        fail_d    = 1'b1;
                        timeout_d = 1'b0;
                    end
                end else if (bus.Clear) begin
                    state_d   = IDLE;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Run       = run;
    assign bus.Busy      = busy;
    assign bus.DISP_RSLT = disp;
    assign bus.Pass      = pass_q;
    assign bus.Fail      = fail_q;
    assign bus.Timeout   = timeout_q;
    assign bus.Slot      = slot_q;

endmodule

// File: tb/tb_chip_test_ctrl.sv
// Directed and randomized checks of chip_test_ctrl against a result/latency model.
module tb_chip_test_ctrl;

    localparam int unsigned TO = 16;

    logic Clk = 1'b0;
    logic Reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    chip_test_ctrl_if #(.NUM_CHIPS(8), .SEL_W(3)) ifa ();
    chip_test_ctrl_if #(.NUM_CHIPS(6), .SEL_W(3)) ifb ();

    chip_test_ctrl #(
        .NUM_CHIPS    (8),
        .SEL_W        (3),
        .TIMEOUT_CYC  (TO),
        .DEBOUNCE_CYC (4)
    ) dut_a (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (ifa)
    );

    chip_test_ctrl #(
        .NUM_CHIPS    (6),
        .SEL_W        (3),
        .TIMEOUT_CYC  (TO),
        .DEBOUNCE_CYC (4)
    ) dut_b (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (ifb)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result model: Done on the captured slot within TO wait cycles decides the result,
    // otherwise the test times out on the last wait cycle.
    function automatic void model(input int done_k, input bit rslt, output int fin_k,
                                  output bit e_pass, output bit e_fail, output bit e_to);
        if (done_k < int'(TO)) begin
            fin_k  = done_k;
            e_pass = rslt;
            e_fail = !rslt;
            e_to   = 1'b0;
        end else begin
            fin_k  = TO - 1;
            e_pass = 1'b0;
            e_fail = 1'b1;
            e_to   = 1'b1;
        end
    endfunction

    // noise: 0 quiet, 1 all other Done bits high and Sel moved, 2 random disturbance.
    task automatic run_test(input string tag, input int sel, input int done_k, input bit rslt,
                            input int noise, input bit clr);
        int         fin_k;
        bit         e_pass, e_fail, e_to;
        logic [7:0] done_v, rslt_v;
        model(done_k, rslt, fin_k, e_pass, e_fail, e_to);
        ifa.Sel   = 3'(sel);
        ifa.Start = 1'b1;
        ifa.Clear = clr;
        step();
        ifa.Start = 1'b0;
        ifa.Clear = 1'b0;
        check({tag, ".run"}, 32'(ifa.Run), 32'd1 << sel);
        check({tag, ".launch_busy"}, 32'(ifa.Busy), 32'd1);
        step();
        check({tag, ".run_off"}, 32'(ifa.Run), 32'd0);
        for (int k = 0; k <= fin_k; k++) begin
            done_v = '0;
            rslt_v = 8'($urandom);
            if (noise == 1) begin
                done_v  = 8'hff;
                ifa.Sel = 3'((sel + 3) % 8);
            end else if (noise == 2) begin
                done_v    = 8'($urandom);
                ifa.Sel   = 3'($urandom);
                ifa.Start = 1'($urandom);
                ifa.Clear = 1'($urandom);
            end
            done_v[sel] = (k == done_k);
            rslt_v[sel] = rslt;
            ifa.Done    = done_v;
            ifa.RSLT    = rslt_v;
            step();
            if (k < fin_k)
                check({tag, ".waiting"}, 32'({ifa.Busy, ifa.Pass, ifa.Fail, ifa.Run != 0}),
                      32'b1000);
        end
        ifa.Done  = '0;
        ifa.Start = 1'b0;
        ifa.Clear = 1'b0;
        check({tag, ".pass"}, 32'(ifa.Pass), 32'(e_pass));
        check({tag, ".fail"}, 32'(ifa.Fail), 32'(e_fail));
        check({tag, ".timeout"}, 32'(ifa.Timeout), 32'(e_to));
        check({tag, ".disp_busy"}, 32'({ifa.DISP_RSLT, ifa.Busy}), 32'b10);
        check({tag, ".slot"}, 32'(ifa.Slot), 32'(sel));
        step();
    endtask

    initial begin
        int runs;
        Reset     = 1'b1;
        ifa.Start = 1'b0; ifa.Clear = 1'b0; ifa.Sel = '0; ifa.Done = '0; ifa.RSLT = '0;
        ifb.Start = 1'b0; ifb.Clear = 1'b0; ifb.Sel = '0; ifb.Done = '0; ifb.RSLT = '0;
        step();
        step();
        Reset = 1'b0;
        check("rst.a", 32'({ifa.Run, ifa.DISP_RSLT, ifa.Busy, ifa.Pass, ifa.Fail, ifa.Timeout,
                            ifa.Slot}), 32'd0);
        check("rst.b", 32'({ifb.Run, ifb.DISP_RSLT, ifb.Busy, ifb.Pass, ifb.Fail, ifb.Timeout,
                            ifb.Slot}), 32'd0);

        run_test("nominal", 2, 2, 1'b1, 0, 1'b0);
        run_test("bad", 5, 3, 1'b0, 0, 1'b0);
        ifa.Clear = 1'b1;
        step();
        ifa.Clear = 1'b0;
        check("clear", 32'({ifa.Pass, ifa.Fail, ifa.Timeout, ifa.DISP_RSLT, ifa.Busy}), 32'd0);

        run_test("timeout", 4, TO + 5, 1'b1, 0, 1'b0);
        run_test("coinc_good", 6, TO - 1, 1'b1, 0, 1'b0);
        run_test("coinc_bad", 0, TO - 1, 1'b0, 0, 1'b0);
        run_test("isolation", 1, 4, 1'b1, 1, 1'b0);
        // Start with a simultaneous Clear from SHOW still retests.
        run_test("start_over_clear", 7, 1, 1'b0, 0, 1'b1);

        // Reset in the third wait cycle aborts without latching.
        ifa.Sel   = 3'd3;
        ifa.Start = 1'b1;
        step();
        ifa.Start = 1'b0;
        step();
        step();
        step();
        Reset       = 1'b1;
        ifa.Done[3] = 1'b1;
        ifa.RSLT[3] = 1'b1;
        step();
        Reset = 1'b0;
        ifa.Done[3] = 1'b0;
        check("rst_wait", 32'({ifa.Run, ifa.DISP_RSLT, ifa.Busy, ifa.Pass, ifa.Fail, ifa.Timeout,
                               ifa.Slot}), 32'd0);
        ifa.Done[3] = 1'b1;
        step();
        ifa.Done[3] = 1'b0;
        check("rst_late_done", 32'({ifa.Pass, ifa.Fail, ifa.Busy, ifa.DISP_RSLT}), 32'd0);

        // Held Start launches exactly one test.
        runs      = 0;
        ifa.Sel   = 3'd0;
        ifa.Start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (ifa.Run != 0) runs++;
        end
        ifa.Start = 1'b0;
        check("held_runs", 32'(runs), 32'd1);
        check("held_timeout", 32'({ifa.Timeout, ifa.Fail}), 32'b11);
        ifa.Clear = 1'b1;
        step();
        ifa.Clear = 1'b0;

        // Empty slots on the six-slot instance.
        for (int s = 6; s < 8; s++) begin
            runs      = 0;
            ifb.Sel   = 3'(s);
            ifb.Start = 1'b1;
            for (int i = 0; i < 6; i++) begin
                step();
                if (ifb.Run != 0) runs++;
            end
            ifb.Start = 1'b0;
            step();
            check("oor_runs", 32'(runs), 32'd0);
            check("oor_flags", 32'({ifb.Fail, ifb.Pass, ifb.Busy}), 32'b100);
        end

        for (int i = 0; i < 20; i++)
            run_test("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, TO + 3)),
                     1'($urandom), 2, 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
